// File: rtl/mdio_pkg.sv
// Shared MDIO constants, request struct and FSM state types for the PHY configurator.
package mdio_pkg;
    localparam logic [1:0] ST       = 2'b01;
    localparam logic [1:0] OP_WR    = 2'b01;
    localparam logic [1:0] OP_RD    = 2'b10;
    localparam logic [4:0] REG_BMCR = 5'd0;
    localparam logic [4:0] REG_ANAR = 5'd4;

    typedef enum logic [2:0] {
        M_IDLE, M_PRE, M_HDR, M_TA, M_DATA, M_IDLE_BIT
    } mst_state_e;

    typedef enum logic [2:0] {
        S_WAIT_START, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_DONE
    } seq_state_e;

    typedef struct packed {
        logic        wren;
        logic        rden;
        logic [4:0]  phyad;
        logic [4:0]  regad;
        logic [15:0] wrdata;
    } miim_req_t;

    // Frame segment that owns bit position idx (64 = trailing idle bit).
    function automatic mst_state_e seg_of(input logic [6:0] idx);
        mst_state_e s;
        if (idx < 7'd32)       s = M_PRE;
        else if (idx < 7'd46)  s = M_HDR;
        else if (idx < 7'd48)  s = M_TA;
        else if (idx < 7'd64)  s = M_DATA;
        else if (idx == 7'd64) s = M_IDLE_BIT;
        else                   s = M_IDLE;
        return s;
    endfunction
endpackage

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: free-running MDC divider, 64-bit frame shifter and tristate driver.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int MDC_HALF = 10
) (
    input  logic        clk,
    input  logic        rstn,
    input  miim_req_t   req,
    output logic        busy,
    output logic [15:0] rddata,
    output logic        rddata_valid,
    output logic        phy_mdc,
    inout  wire         phy_mdio
);
    logic [7:0]  div;
    logic        tick, fall, rise;
    mst_state_e  state, state_d;
    logic [6:0]  idx;
    logic [6:0]  idx_nx;
    logic [63:0] frame;
    logic        is_rd;
    logic        oe, mdo;
    logic [15:0] rd_sh;

    assign tick     = (div == 8'(MDC_HALF - 1));
    assign fall     = tick & phy_mdc;
    assign rise     = tick & ~phy_mdc;
    assign idx_nx   = idx + 7'd1;
    assign busy     = (state != M_IDLE);
    assign phy_mdio = oe ? mdo : 1'bz;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div     <= '0;
            phy_mdc <= 1'b0;
        end else if (tick) begin
            div     <= '0;
            phy_mdc <= ~phy_mdc;
        end else begin
            div <= div + 8'd1;
        end
    end

    // idx is the frame bit currently on the line; all-ones until the first launch.
    always_comb begin
        state_d = state;
        case (state)
            M_IDLE:  if (req.wren || req.rden) state_d = M_PRE;
            default: if (fall) state_d = seg_of(idx_nx);
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= M_IDLE;
        else       state <= state_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx          <= '1;
            frame        <= '0;
            is_rd        <= 1'b0;
            oe           <= 1'b0;
            mdo          <= 1'b1;
            rd_sh        <= '0;
            rddata       <= '0;
            rddata_valid <= 1'b0;
        end else begin
            rddata_valid <= 1'b0;
            if (state == M_IDLE) begin
                if (req.wren || req.rden) begin
                    idx   <= '1;
                    is_rd <= ~req.wren;
                    frame <= {32'hFFFF_FFFF, ST, req.wren ? OP_WR : OP_RD, req.phyad, req.regad,
                              req.wren ? 2'b10 : 2'b00, req.wren ? req.wrdata : 16'h0000};
                end
            end else begin
                if (rise && state == M_DATA) rd_sh <= {rd_sh[14:0], phy_mdio};
                if (fall) begin
                    idx <= idx_nx;
                    // Reads hand the line to the PHY from the first TA bit onward.
                    oe  <= (idx_nx < (is_rd ? 7'd46 : 7'd64));
                    mdo <= frame[~idx_nx[5:0]];
                    if (state == M_IDLE_BIT && is_rd) begin
                        rddata       <= rd_sh;
                        rddata_valid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/mdio_phy_config.sv
// Power-up PHY configurator: writes BMCR, reads back ANAR, then holds finish_flag.
module mdio_phy_config
    import mdio_pkg::*;
#(
    parameter int          MDC_HALF    = 10,
    parameter int          START_DELAY = 100,
    parameter logic [4:0]  PHY_ADDR    = 5'h01,
    parameter logic [15:0] BMCR_VAL    = 16'h3100
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        phy_mdc,
    inout  wire         phy_mdio,
    output logic [15:0] miim_rddata,
    output logic        miim_rddata_valid,
    output logic        miim_busy,
    output logic        finish_flag
);
    seq_state_e state, state_d;
    logic [15:0] dly;
    logic        seen_busy;
    miim_req_t   req;

    always_comb begin
        state_d   = state;
        req       = '0;
        req.phyad = PHY_ADDR;
        case (state)
            S_WAIT_START: if (dly == 16'(START_DELAY - 1)) state_d = S_WR_REQ;
            S_WR_REQ: begin
                req.wren   = 1'b1;
                req.regad  = REG_BMCR;
                req.wrdata = BMCR_VAL;
                state_d    = S_WR_WAIT;
            end
            S_WR_WAIT: if (seen_busy && !miim_busy) state_d = S_RD_REQ;
            S_RD_REQ: begin
                req.rden  = 1'b1;
                req.regad = REG_ANAR;
                state_d   = S_RD_WAIT;
            end
            S_RD_WAIT: if (miim_rddata_valid) state_d = S_DONE;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_WAIT_START;
            dly       <= '0;
            seen_busy <= 1'b0;
        end else begin
            state     <= state_d;
            if (state == S_WAIT_START) dly <= dly + 16'd1;
            seen_busy <= (state == S_WR_WAIT) && (seen_busy || miim_busy);
        end
    end

    assign finish_flag = (state == S_DONE);

    mdio_master #(.MDC_HALF(MDC_HALF)) u_master (
        .clk          (clk),
        .rstn         (rstn),
        .req          (req),
        .busy         (miim_busy),
        .rddata       (miim_rddata),
        .rddata_valid (miim_rddata_valid),
        .phy_mdc      (phy_mdc),
        .phy_mdio     (phy_mdio)
    );
endmodule

// File: tb/tb_mdio_phy_config.sv
// Bench for mdio_phy_config: PHY frame decoder on a pulled-up MDIO line plus a second master for request-port cases.
module tb_mdio_phy_config;
    import mdio_pkg::*;

    localparam int HALF = 10;
    localparam int SD   = 100;

    typedef struct packed {
        int          pre;
        logic [1:0]  st;
        logic [1:0]  op;
        logic [4:0]  phyad;
        logic [4:0]  regad;
        logic [1:0]  ta;
        logic [15:0] data;
    } frm_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    wire         phy_mdio;
    logic        phy_mdc;
    logic [15:0] miim_rddata;
    logic        miim_rddata_valid, miim_busy, finish_flag;
    miim_req_t   m2_req;
    logic        m2_busy, m2_valid, m2_mdc;
    logic [15:0] m2_rddata;
    logic        phy_oe = 1'b0;
    logic        phy_do = 1'b0;

    int total = 0;
    int passed = 0;
    frm_t exp_q[$];
    frm_t obs_q[$];

    pullup (phy_mdio);
    assign phy_mdio = phy_oe ? phy_do : 1'bz;
    always #20 clk = ~clk;

    mdio_phy_config #(.MDC_HALF(HALF), .START_DELAY(SD), .PHY_ADDR(5'h01), .BMCR_VAL(16'h3100)) dut (
        .clk(clk), .rstn(rstn), .phy_mdc(phy_mdc), .phy_mdio(phy_mdio), .miim_rddata(miim_rddata),
        .miim_rddata_valid(miim_rddata_valid), .miim_busy(miim_busy), .finish_flag(finish_flag)
    );

    mdio_master #(.MDC_HALF(HALF)) m2 (
        .clk(clk), .rstn(rstn), .req(m2_req), .busy(m2_busy), .rddata(m2_rddata),
        .rddata_valid(m2_valid), .phy_mdc(m2_mdc), .phy_mdio(phy_mdio)
    );

    // PHY model: samples on MDC rise, drives read data after MDC fall; also logs line-change timing.
    int          ones = 0, pos = -1, cyc = 0, last_fall = 0, tim_err = 0, tim_chg = 0;
    bit          armed = 0, done = 0, resp = 0;
    logic        mdc_q = 1'b0, mdio_q = 1'b1, rstn_q = 1'b0, busy_q = 1'b0;
    logic [31:0] sh = '0;
    logic [15:0] rdv = '0;
    logic [15:0] regs [0:31];

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 16'h0000;
        regs[4] = 16'h01E1;
    end

    always @(posedge clk) begin : phy_model
        logic mdc, b, busy_any;
        int   nb;
        frm_t f;
        #1;
        cyc++;
        mdc      = m2_busy ? m2_mdc : phy_mdc;
        busy_any = miim_busy | m2_busy;
        b        = phy_mdio;
        if (!mdc && mdc_q) last_fall = cyc;
        if (rstn && rstn_q && b !== mdio_q) begin
            tim_chg++;
            if ((cyc - last_fall) >= HALF) tim_err++;
        end
        mdio_q = b;
        rstn_q = rstn;
        if (!rstn) begin
            armed = 0; pos = -1; ones = 0; done = 0; resp = 0; phy_oe = 1'b0;
        end else if (mdc && !mdc_q) begin
            if (armed && !done) begin
                if (pos < 0) begin
                    if (b) ones++;
                    else begin pos = 0; sh = '0; end
                end else begin
                    pos++;
                    sh = {sh[30:0], b};
                end
                if (pos == 13) begin
                    resp = (sh[11:10] == OP_RD) && (sh[9:5] == 5'd1);
                    rdv  = regs[sh[4:0]];
                end
                if (pos == 31) begin
                    f = '{pre: ones, st: sh[31:30], op: sh[29:28], phyad: sh[27:23],
                          regad: sh[22:18], ta: sh[17:16], data: sh[15:0]};
                    if (f.op == OP_WR && f.phyad == 5'd1) regs[f.regad] = f.data;
                    obs_q.push_back(f);
                    done = 1;
                end
            end
        end else if (!mdc && mdc_q) begin
            if (!busy_any) begin
                armed = 0; pos = -1; ones = 0; done = 0; resp = 0; phy_oe = 1'b0;
            end else begin
                if (busy_q) armed = 1;
                if (resp) begin
                    nb = pos + 1;
                    if (nb == 15) begin phy_oe = 1'b1; phy_do = 1'b0; end
                    else if (nb >= 16 && nb <= 31) begin phy_oe = 1'b1; phy_do = rdv[31 - nb]; end
                    else phy_oe = 1'b0;
                end
            end
        end
        busy_q = busy_any;
        mdc_q  = mdc;
    end

    function automatic frm_t mk(input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra,
                                input logic [1:0] ta, input logic [15:0] d);
        return '{pre: 32, st: ST, op: op, phyad: pa, regad: ra, ta: ta, data: d};
    endfunction

    function automatic string fs(input frm_t f);
        return $sformatf("pre=%0d st=%b op=%b phy=%h reg=%h ta=%b data=%h",
                         f.pre, f.st, f.op, f.phyad, f.regad, f.ta, f.data);
    endfunction

    task automatic m2_pulse(input bit w, input bit r, input logic [4:0] pa, input logic [4:0] ra,
                            input logic [15:0] d);
        m2_req = '{wren: w, rden: r, phyad: pa, regad: ra, wrdata: d};
        @(negedge clk);
        m2_req = '0;
    endtask

    task automatic wait_m2(output bit to, output int vc, output logic [15:0] vd);
        int n = 0;
        vc = 0; vd = '0;
        while (m2_busy && n < 3000) begin
            @(negedge clk); n++;
            if (m2_valid) begin vc++; vd = m2_rddata; end
        end
        to = m2_busy;
    endtask

    task automatic test_reset();
        bit bad_mdc = 0, bad_line = 0, bad_out = 0;
        rstn = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (phy_mdc !== 1'b0) bad_mdc = 1;
            if (phy_mdio !== 1'b1) bad_line = 1;
            if (miim_busy !== 1'b0 || miim_rddata_valid !== 1'b0 || finish_flag !== 1'b0 || m2_busy !== 1'b0) bad_out = 1;
        end
        total++; if (bad_mdc) $display("FAIL reset_mdc: toggled=%0b required 0", bad_mdc); else passed++;
        total++; if (bad_line) $display("FAIL reset_mdio: disturbed=%0b required released high", bad_line); else passed++;
        total++; if (bad_out) $display("FAIL reset_flags: nonzero=%0b required all 0", bad_out); else passed++;
        total++; if (miim_rddata !== 16'h0000) $display("FAIL reset_rddata: got %h required 0000", miim_rddata); else passed++;
    endtask

    task automatic test_sequence(input bit long_hold);
        int n; bit seen; logic pb; bit fin; bit bad; frm_t e, o;
        exp_q.push_back(mk(OP_WR, 5'd1, REG_BMCR, 2'b10, 16'h3100));
        exp_q.push_back(mk(OP_RD, 5'd1, REG_ANAR, 2'b10, 16'h01E1));
        @(negedge clk); rstn = 1'b1;
        n = 0;
        while (!miim_busy && n < SD + 50) begin @(negedge clk); n++; end
        total++;
        if (n < SD || n > SD + 2) $display("FAIL start_delay: busy after %0d clks required %0d..%0d", n, SD, SD + 2);
        else passed++;
        pb = miim_busy; seen = 0; n = 0;
        while (!seen && n < 4000) begin
            @(negedge clk); n++;
            if (miim_rddata_valid) seen = 1; else pb = miim_busy;
        end
        total++; if (!seen) $display("FAIL rd_valid_timeout: waited %0d clks required a valid pulse", n); else passed++;
        total++; if (miim_rddata !== 16'h01E1) $display("FAIL rd_data: got %h required 01E1", miim_rddata); else passed++;
        total++;
        if (!(pb === 1'b1 && miim_busy === 1'b0))
            $display("FAIL valid_busy_fall: busy prev=%b now=%b required 1 then 0", pb, miim_busy);
        else passed++;
        fin = (finish_flag === 1'b1);
        @(negedge clk);
        fin = fin || (finish_flag === 1'b1);
        total++; if (miim_rddata_valid !== 1'b0) $display("FAIL valid_width: second clk valid=%b required 0", miim_rddata_valid); else passed++;
        total++; if (!fin) $display("FAIL finish_flag: got %b required 1 within one clk", finish_flag); else passed++;
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) $display("FAIL seq_frame%0d: got no frame required %s", i, fs(e));
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL seq_frame%0d: got %s required %s", i, fs(o), fs(e));
                else passed++;
            end
        end
        if (long_hold) begin
            bad = 0;
            repeat (2500) begin @(negedge clk); if (finish_flag !== 1'b1 || miim_busy !== 1'b0) bad = 1; end
            total++; if (bad) $display("FAIL finish_hold: dropped_or_busy=%0b required steady done", bad); else passed++;
        end
    endtask

    task automatic test_busy();
        bit to; int vc; logic [15:0] vd; frm_t e, o; bit rose = 0;
        e = mk(OP_WR, 5'd1, 5'd2, 2'b10, 16'h1234);
        m2_pulse(1, 0, 5'd1, 5'd2, 16'h1234);
        repeat (200) @(negedge clk);
        total++; if (m2_busy !== 1'b1) $display("FAIL busy_mid_frame: got %b required 1", m2_busy); else passed++;
        m2_pulse(1, 0, 5'd1, 5'd3, 16'hABCD);
        wait_m2(to, vc, vd);
        total++; if (to) $display("FAIL busy_timeout: busy=%b required 0", m2_busy); else passed++;
        repeat (100) begin @(negedge clk); if (m2_busy) rose = 1; end
        total++;
        if (rose || obs_q.size() != 1) $display("FAIL ignored_req: extra_busy=%0b frames=%0d required 0 and 1", rose, obs_q.size());
        else passed++;
        total++;
        if (obs_q.size() == 0) $display("FAIL busy_frame: got none required %s", fs(e));
        else begin
            o = obs_q.pop_front();
            if (o !== e) $display("FAIL busy_frame: got %s required %s", fs(o), fs(e)); else passed++;
        end
        obs_q.delete();
        e = mk(OP_WR, 5'd1, 5'd3, 2'b10, 16'h5A5A);
        m2_pulse(1, 1, 5'd1, 5'd3, 16'h5A5A);
        wait_m2(to, vc, vd);
        total++; if (vc != 0) $display("FAIL wr_wins_valid: got %0d pulses required 0", vc); else passed++;
        total++;
        if (obs_q.size() == 0) $display("FAIL wr_wins_frame: got none required %s", fs(e));
        else begin
            o = obs_q.pop_front();
            if (o !== e) $display("FAIL wr_wins_frame: got %s required %s", fs(o), fs(e)); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        bit to; int vc; logic [15:0] vd; frm_t o;
        exp_q.push_back(mk(OP_RD, 5'd1, 5'd3, 2'b10, 16'h5A5A));
        exp_q.push_back(mk(OP_RD, 5'd7, 5'd4, 2'b11, 16'hFFFF));
        m2_pulse(0, 1, 5'd1, 5'd3, 16'h0000);
        wait_m2(to, vc, vd);
        total++; if (vc != 1 || vd !== 16'h5A5A) $display("FAIL rd_back: pulses=%0d data=%h required 1 and 5A5A", vc, vd); else passed++;
        m2_pulse(0, 1, 5'd7, 5'd4, 16'h0000);
        wait_m2(to, vc, vd);
        total++; if (vc != 1 || vd !== 16'hFFFF) $display("FAIL rd_noresp: pulses=%0d data=%h required 1 and FFFF", vc, vd); else passed++;
        for (int i = 0; i < 2; i++) begin
            frm_t e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) $display("FAIL b2b_frame%0d: got none required %s", i, fs(e));
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL b2b_frame%0d: got %s required %s", i, fs(o), fs(e)); else passed++;
            end
        end
    endtask

    task automatic test_midframe_reset();
        int n, falls; logic prev;
        @(negedge clk); rstn = 1'b0;
        repeat (5) @(negedge clk);
        obs_q.delete(); exp_q.delete();
        rstn = 1'b1;
        n = 0;
        while (!miim_busy && n < SD + 50) begin @(negedge clk); n++; end
        prev = phy_mdc; falls = 0; n = 0;
        while (falls < 49 && n < 2000) begin
            @(negedge clk); n++;
            if (prev && !phy_mdc) falls++;
            prev = phy_mdc;
        end
        total++; if (phy_mdio !== 1'b0) $display("FAIL data_msb_drive: got %b required 0", phy_mdio); else passed++;
        #5 rstn = 1'b0;
        #1;
        total++;
        if (phy_mdio !== 1'b1 || miim_busy !== 1'b0 || phy_mdc !== 1'b0)
            $display("FAIL abort_release: mdio=%b busy=%b mdc=%b required 1 0 0", phy_mdio, miim_busy, phy_mdc);
        else passed++;
        repeat (5) @(negedge clk);
        total++; if (obs_q.size() != 0) $display("FAIL abort_frames: got %0d required 0", obs_q.size()); else passed++;
        test_sequence(0);
    endtask

    task automatic test_timing();
        int n = 0, r1 = -1, r2 = -1; logic prev = phy_mdc;
        while (r2 < 0 && n < 200) begin
            @(negedge clk); n++;
            if (!prev && phy_mdc) begin if (r1 < 0) r1 = n; else r2 = n; end
            prev = phy_mdc;
        end
        total++; if (r2 - r1 != 2 * HALF) $display("FAIL mdc_period: got %0d clks required %0d", r2 - r1, 2 * HALF); else passed++;
        total++;
        if (tim_err != 0 || tim_chg == 0) $display("FAIL mdio_timing: late=%0d changes=%0d required 0 and >0", tim_err, tim_chg);
        else passed++;
    endtask

    initial begin
        m2_req = '0;
        test_reset();
        test_sequence(1);
        test_busy();
        test_back_to_back();
        test_midframe_reset();
        test_timing();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
